// File: rtl/lunc_pkg.sv
// Shared definitions for the case-transform escape-command encoder.
//   mode_e      : downstream case mode (N pass-through, L lower, U upper, C change)
//   ESC, CH_*   : escape byte and the four command letters
//   mode_letter : maps a mode to its command letter
//   state_e     : encoder output-sequencing states
package lunc_pkg;

    typedef enum logic [1:0] {
        MODE_N = 2'd0,
        MODE_L = 2'd1,
        MODE_U = 2'd2,
        MODE_C = 2'd3
    } mode_e;

    localparam logic [7:0] ESC  = 8'h1B;
    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_U = 8'h55;
    localparam logic [7:0] CH_N = 8'h4E;
    localparam logic [7:0] CH_C = 8'h43;

    function automatic logic [7:0] mode_letter(input mode_e m);
        logic [7:0] ch;
        case (m)
            MODE_L:  ch = CH_L;
            MODE_U:  ch = CH_U;
            MODE_C:  ch = CH_C;
            default: ch = CH_N;
        endcase
        return ch;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ESC  = 2'd1,
        S_CMD  = 2'd2,
        S_DATA = 2'd3
    } state_e;

endpackage

// File: rtl/lunc_encoder.sv
// Escape-command encoder: turns (byte, requested mode) pairs into the
// ESC+letter command stream consumed by the case-transform filter.
// A command is inserted only when the requested mode differs from the mode
// established downstream, when a resync is pending, or when the byte is a
// literal ESC (which is carried by the command's own ESC).
//
// Ports:
//   clock, reset           rising-edge clock, async active-low reset
//   in_data/in_mode        source byte and its requested mode
//   in_valid/in_ready      source handshake (in_ready is combinational)
//   out_data/out_valid     registered encoded byte to the filter
//   out_ready              downstream accepts out_data
//   sync_req               pulse: force a command before the next data byte
//   cur_mode               mode currently established downstream
//   cmd_count              saturating count of ESC+letter pairs emitted
module lunc_encoder
    import lunc_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter bit FORCE_INITIAL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             sync_req,
    output logic [1:0]       cur_mode,
    output logic [CNT_W-1:0] cmd_count
);

    state_e           state_q, state_d;
    logic [7:0]       hold_byte_q, hold_byte_d;
    mode_e            hold_mode_q, hold_mode_d;
    mode_e            cur_mode_q, cur_mode_d;
    logic             force_q, force_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic  out_fire, cmd_fire, final_beat, in_fire, need_cmd, capture;
    mode_e mode_eff;

    always_comb begin
        out_fire   = out_valid_q && out_ready;
        cmd_fire   = (state_q == S_CMD) && out_fire;
        // A literal ESC ends on its command letter; no separate data beat.
        final_beat = (state_q == S_DATA) ||
                     ((state_q == S_CMD) && (hold_byte_q == ESC));
        in_ready   = (state_q == S_IDLE) || (final_beat && out_ready);
        in_fire    = in_valid && in_ready;

        // A byte captured on the edge that completes a command must see the
        // mode/force that command establishes, not the stale registers.
        mode_eff   = cmd_fire ? hold_mode_q : cur_mode_q;
        force_d    = (force_q && !cmd_fire) || sync_req;
        need_cmd   = (mode_e'(in_mode) != mode_eff) || force_d ||
                     (in_data == ESC);
        cur_mode_d = mode_eff;

        cmd_cnt_d = cmd_cnt_q;
        if (cmd_fire && (cmd_cnt_q != {CNT_W{1'b1}}))
            cmd_cnt_d = cmd_cnt_q + CNT_W'(1);

        state_d     = state_q;
        hold_byte_d = hold_byte_q;
        hold_mode_d = hold_mode_q;
        capture     = 1'b0;

        case (state_q)
            S_IDLE: capture = in_fire;
            S_ESC:  if (out_fire) state_d = S_CMD;
            S_CMD: begin
                if (out_fire) begin
                    if (hold_byte_q == ESC) begin
                        state_d = S_IDLE;
                        capture = in_fire;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (out_fire) begin
                    state_d = S_IDLE;
                    capture = in_fire;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            hold_byte_d = in_data;
            hold_mode_d = mode_e'(in_mode);
            state_d     = need_cmd ? S_ESC : S_DATA;
        end

        // Output registers mirror the state being entered, so they hold
        // steady for free whenever back-pressure freezes the state.
        out_valid_d = (state_d != S_IDLE);
        case (state_d)
            S_ESC:   out_data_d = ESC;
            S_CMD:   out_data_d = mode_letter(hold_mode_d);
            S_DATA:  out_data_d = hold_byte_d;
            default: out_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_byte_q <= 8'h00;
            hold_mode_q <= MODE_N;
            cur_mode_q  <= MODE_N;
            force_q     <= FORCE_INITIAL;
            cmd_cnt_q   <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_byte_q <= hold_byte_d;
            hold_mode_q <= hold_mode_d;
            cur_mode_q  <= cur_mode_d;
            force_q     <= force_d;
            cmd_cnt_q   <= cmd_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign cur_mode  = cur_mode_q;
    assign cmd_count = cmd_cnt_q;

endmodule

// File: tb/tb_lunc_encoder.sv
`timescale 1ns/1ps
module tb_lunc_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic [1:0]  in_mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sync_req;
    logic [1:0]  cur_mode;
    logic [15:0] cmd_count;

    logic        f_in_ready;
    logic [7:0]  f_out_data;
    logic        f_out_valid;
    logic [1:0]  f_cur_mode;
    logic [15:0] f_cmd_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [1:0] tb_mode;
    bit         tb_force;
    int         tb_cmds;
    bit         rnd_done;

    always #5 clock = ~clock;

    lunc_encoder #(.CNT_W(16), .FORCE_INITIAL(1'b0)) u_dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sync_req(sync_req),
        .cur_mode(cur_mode), .cmd_count(cmd_count)
    );

    lunc_encoder #(.CNT_W(16), .FORCE_INITIAL(1'b1)) u_dut_f (
        .clock(clock), .reset(reset), .in_data(in_data), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(f_in_ready), .out_data(f_out_data),
        .out_valid(f_out_valid), .out_ready(out_ready), .sync_req(sync_req),
        .cur_mode(f_cur_mode), .cmd_count(f_cmd_count)
    );

    function automatic logic [7:0] tb_letter(input logic [1:0] m);
        case (m)
            2'd1:    return 8'h4C;
            2'd2:    return 8'h55;
            2'd3:    return 8'h43;
            default: return 8'h4E;
        endcase
    endfunction

    function automatic bit is_letter(input logic [7:0] b);
        return (b == 8'h4C) || (b == 8'h55) || (b == 8'h4E) || (b == 8'h43);
    endfunction

    // Stream-level reference: what the filter should receive for one byte.
    task automatic model_push(input logic [7:0] d, input logic [1:0] m);
        if ((m != tb_mode) || tb_force || (d == 8'h1B)) begin
            exp_q.push_back(8'h1B);
            exp_q.push_back(tb_letter(m));
            tb_mode  = m;
            tb_force = 1'b0;
            tb_cmds++;
        end
        if (d != 8'h1B) exp_q.push_back(d);
    endtask

    // Pops the scoreboard for every accepted output beat, sampled just
    // before the edge when all inputs are settled.
    task automatic monitor_loop();
        logic [7:0] exp;
        bit prev_esc;
        prev_esc = 1'b0;
        forever begin
            @(negedge clock);
            #4;
            if (reset !== 1'b1) begin
                prev_esc = 1'b0;
            end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got %h, none expected", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL out_stream: got %h, expected %h", out_data, exp);
                    end
                end
                if (prev_esc) begin
                    checks++;
                    if (!is_letter(out_data)) begin
                        errors++;
                        $display("FAIL esc_follow: got %h after ESC, expected a letter", out_data);
                    end
                end
                prev_esc = (out_data == 8'h1B);
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] m, input bit s, output int waits);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        sync_req = s;
        if (s) tb_force = 1'b1;
        model_push(d, m);
        waits = 0;
        forever begin
            @(negedge clock);
            #3;
            if (in_ready === 1'b1) break;
            waits++;
            if (waits > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck %b, expected 1", in_ready);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        sync_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: %0d bytes pending, out_valid=%b, expected 0/0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_data = 8'h00; in_mode = 2'd0; in_valid = 1'b0;
        out_ready = 1'b1; sync_req = 1'b0;
        tb_mode = 2'd0; tb_force = 1'b0; tb_cmds = 0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        checks++; if (out_data !== 8'h00)   begin errors++; $display("FAIL rst_out_data: got %h, expected 00", out_data); end
        checks++; if (cur_mode !== 2'd0)    begin errors++; $display("FAIL rst_cur_mode: got %0d, expected 0", cur_mode); end
        checks++; if (cmd_count !== 16'd0)  begin errors++; $display("FAIL rst_cmd_count: got %0d, expected 0", cmd_count); end
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_force_initial();
        logic [7:0] fexp [3];
        int w;
        fexp[0] = 8'h1B; fexp[1] = 8'h4E; fexp[2] = 8'h30;
        send(8'h30, 2'd0, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (f_out_valid !== 1'b1 || f_out_data !== fexp[i]) begin
                errors++;
                $display("FAIL force_init_beat%0d: got v=%b %h, expected v=1 %h", i, f_out_valid, f_out_data, fexp[i]);
            end
            @(posedge clock);
            #1;
        end
        drain();
        checks++; if (f_cmd_count !== 16'd1) begin errors++; $display("FAIL force_init_count: got %0d, expected 1", f_cmd_count); end
        checks++; if (cmd_count !== 16'd0)   begin errors++; $display("FAIL noforce_count: got %0d, expected 0", cmd_count); end
    endtask

    task automatic test_pass();
        int w0, w1;
        send(8'h61, 2'd0, 1'b0, w0);
        send(8'h62, 2'd0, 1'b0, w1);
        drain();
        checks++; if (w1 != 0)            begin errors++; $display("FAIL pass_throughput: waited %0d, expected 0", w1); end
        checks++; if (cmd_count !== 16'd0) begin errors++; $display("FAIL pass_count: got %0d, expected 0", cmd_count); end
        checks++; if (cur_mode !== 2'd0)   begin errors++; $display("FAIL pass_mode: got %0d, expected 0", cur_mode); end
    endtask

    task automatic test_mode_change();
        int w0, w1;
        send(8'h41, 2'd1, 1'b0, w0);
        send(8'h42, 2'd1, 1'b0, w1);
        drain();
        checks++; if (w1 != 2)             begin errors++; $display("FAIL mode_stall: waited %0d, expected 2", w1); end
        checks++; if (cur_mode !== 2'd1)   begin errors++; $display("FAIL mode_cur: got %0d, expected 1", cur_mode); end
        checks++; if (cmd_count !== 16'd1) begin errors++; $display("FAIL mode_count: got %0d, expected 1", cmd_count); end
    endtask

    task automatic test_literal_esc();
        int w0, w1;
        send(8'h1B, 2'd1, 1'b0, w0);
        send(8'h7A, 2'd1, 1'b0, w1);
        drain();
        checks++; if (w1 != 1)             begin errors++; $display("FAIL esc_stall: waited %0d, expected 1", w1); end
        checks++; if (cmd_count !== 16'd2) begin errors++; $display("FAIL esc_count: got %0d, expected 2", cmd_count); end
    endtask

    task automatic test_backpressure();
        in_data = 8'h75; in_mode = 2'd2; in_valid = 1'b1;
        model_push(8'h75, 2'd2);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h55) begin
                errors++;
                $display("FAIL bp_hold: got v=%b %h, expected v=1 55", out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        drain();
        checks++; if (cur_mode !== 2'd2) begin errors++; $display("FAIL bp_mode: got %0d, expected 2", cur_mode); end
    endtask

    task automatic test_reset_mid();
        in_data = 8'h41; in_mode = 2'd0; in_valid = 1'b1;
        exp_q.push_back(8'h1B);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL midrst_valid: got %b, expected 0", out_valid); end
        checks++; if (cur_mode !== 2'd0)   begin errors++; $display("FAIL midrst_mode: got %0d, expected 0", cur_mode); end
        checks++; if (cmd_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d, expected 0", cmd_count); end
        checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL midrst_esc_seen: %0d pending, expected 0", exp_q.size()); end
        exp_q.delete();
        tb_mode = 2'd0; tb_force = 1'b0; tb_cmds = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_sync();
        int w;
        sync_req = 1'b1;
        tb_force = 1'b1;
        @(posedge clock); #1;
        sync_req = 1'b0;
        send(8'h30, 2'd0, 1'b0, w);
        drain();
        send(8'h31, 2'd0, 1'b1, w);
        drain();
        send(8'h32, 2'd0, 1'b0, w);
        drain();
        checks++; if (cmd_count !== 16'd2) begin errors++; $display("FAIL sync_count: got %0d, expected 2", cmd_count); end
    endtask

    task automatic test_random();
        logic [7:0] pool [4];
        int w;
        pool[0] = 8'h61; pool[1] = 8'h1B; pool[2] = 8'h41; pool[3] = 8'h7A;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    send(pool[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 1'b0, w);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++; if (cmd_count !== 16'(tb_cmds)) begin errors++; $display("FAIL rnd_count: got %0d, expected %0d", cmd_count, tb_cmds); end
        checks++; if (cur_mode !== tb_mode)       begin errors++; $display("FAIL rnd_mode: got %0d, expected %0d", cur_mode, tb_mode); end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_force_initial();
        test_pass();
        test_mode_change();
        test_literal_esc();
        test_backpressure();
        test_reset_mid();
        test_sync();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
